// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_pkg : shared encodings and the M->W bundle type for the pipeline     |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
package pipe_pkg;

  localparam int unsigned WB_ALU = 0;
  localparam int unsigned WB_DM  = 1;
  localparam int unsigned WB_PC8 = 2;
  localparam int unsigned WB_HI  = 3;
  localparam int unsigned WB_LO  = 4;

  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LB  = 3'd1,
    LD_LBU = 3'd2,
    LD_LH  = 3'd3,
    LD_LHU = 3'd4
  } ld_type_e;

  // wb_sel is held outside this struct because its width is a module parameter.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        we;
    ld_type_e    ld_type;
    logic [1:0]  addr_lo;
    logic [31:0] alu;
    logic [31:0] dm;
    logic [31:0] hi;
    logic [31:0] lo;
  } m_bundle_t;

  localparam m_bundle_t M_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/w_writeback_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | w_writeback_if : M-stage result bundle in, GRF write port and status out  |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
interface w_writeback_if #(
  parameter int WB_SEL_W = 3,
  parameter int CNT_W    = 32
);
  logic                M_valid;
  logic                M_flush;
  logic [31:0]         M_pc;
  logic [4:0]          M_rd;
  logic                M_we;
  logic [WB_SEL_W-1:0] M_wb_sel;
  logic [2:0]          M_ld_type;
  logic [1:0]          M_addr_lo;
  logic [31:0]         M_alu;
  logic [31:0]         M_dm;
  logic [31:0]         M_hi;
  logic [31:0]         M_lo;

  logic [4:0]          W_A3;
  logic [31:0]         W_WD3;
  logic                W_WE;
  logic [31:0]         W_pc;
  logic                W_fwd_valid;
  logic                W_ld_misalign;
  logic [CNT_W-1:0]    retire_cnt;

  modport master (
    output M_valid, M_flush, M_pc, M_rd, M_we, M_wb_sel, M_ld_type, M_addr_lo,
           M_alu, M_dm, M_hi, M_lo,
    input  W_A3, W_WD3, W_WE, W_pc, W_fwd_valid, W_ld_misalign, retire_cnt
  );

  modport slave (
    input  M_valid, M_flush, M_pc, M_rd, M_we, M_wb_sel, M_ld_type, M_addr_lo,
           M_alu, M_dm, M_hi, M_lo,
    output W_A3, W_WD3, W_WE, W_pc, W_fwd_valid, W_ld_misalign, retire_cnt
  );
endinterface
`default_nettype wire

// File: rtl/w_load_ext.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | w_load_ext : load byte/halfword extraction, extension and alignment check |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module w_load_ext
  import pipe_pkg::*;
(
  input  logic [31:0] dm,
  input  ld_type_e    ld_type,
  input  logic [1:0]  addr_lo,
  output logic [31:0] ext_data,
  output logic        misalign
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = dm[{addr_lo, 3'b000} +: 8];
  assign w_half = dm[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    ext_data = dm;
    misalign = 1'b0;
    case (ld_type)
      LD_LW:  misalign = (addr_lo != 2'd0);
      LD_LB:  ext_data = {{24{w_byte[7]}}, w_byte};
      LD_LBU: ext_data = {24'd0, w_byte};
      LD_LH: begin
        ext_data = {{16{w_half[15]}}, w_half};
        misalign = addr_lo[0];
      end
      LD_LHU: begin
        ext_data = {16'd0, w_half};
        misalign = addr_lo[0];
      end
      default: ext_data = dm;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/w_writeback.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | w_writeback : W-stage bundle register, result mux, GRF write port driver  |
// | Optional macro WB_TRACE_EN enables the commit trace.   Revision : 1.0     |
// +--------------------------------------------------------------------------+
module w_writeback
  import pipe_pkg::*;
#(
  parameter int WB_SEL_W = 3,
  parameter int CNT_W    = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  w_writeback_if.slave wb
);
  m_bundle_t           r_bundle;
  m_bundle_t           w_next;
  logic [WB_SEL_W-1:0] r_wb_sel;
  logic [WB_SEL_W-1:0] w_next_sel;
  logic [CNT_W-1:0]    r_retire_cnt;

  logic [31:0]         w_ext_data;
  logic                w_ext_misalign;
  logic [31:0]         w_wd;
  logic                w_sel_ok;
  logic                w_misalign;
  logic                w_we;

  // Flush outranks valid; either one turns the capture into a bubble.
  always_comb begin
    w_next     = M_BUBBLE;
    w_next_sel = '0;
    if (wb.M_valid && !wb.M_flush) begin
      w_next.valid   = 1'b1;
      w_next.pc      = wb.M_pc;
      w_next.rd      = wb.M_rd;
      w_next.we      = wb.M_we;
      w_next.ld_type = ld_type_e'(wb.M_ld_type);
      w_next.addr_lo = wb.M_addr_lo;
      w_next.alu     = wb.M_alu;
      w_next.dm      = wb.M_dm;
      w_next.hi      = wb.M_hi;
      w_next.lo      = wb.M_lo;
      w_next_sel     = wb.M_wb_sel;
    end
  end

  // The counter advances on the same edge that latches a real instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bundle     <= M_BUBBLE;
      r_wb_sel     <= '0;
      r_retire_cnt <= '0;
    end else begin
      r_bundle     <= w_next;
      r_wb_sel     <= w_next_sel;
      r_retire_cnt <= r_retire_cnt + CNT_W'(w_next.valid);
    end
  end

  w_load_ext u_load_ext (
    .dm       (r_bundle.dm),
    .ld_type  (r_bundle.ld_type),
    .addr_lo  (r_bundle.addr_lo),
    .ext_data (w_ext_data),
    .misalign (w_ext_misalign)
  );

  always_comb begin
    w_wd     = '0;
    w_sel_ok = 1'b1;
    case (r_wb_sel)
      WB_SEL_W'(WB_ALU): w_wd = r_bundle.alu;
      WB_SEL_W'(WB_DM):  w_wd = w_ext_data;
      WB_SEL_W'(WB_PC8): w_wd = r_bundle.pc + 32'd8;
      WB_SEL_W'(WB_HI):  w_wd = r_bundle.hi;
      WB_SEL_W'(WB_LO):  w_wd = r_bundle.lo;
      default:           w_sel_ok = 1'b0;
    endcase
  end

  assign w_misalign = r_bundle.valid && (r_wb_sel == WB_SEL_W'(WB_DM)) && w_ext_misalign;
  // $0 is never written so the GRF bypass cannot leak a nonzero $0.
  assign w_we       = r_bundle.valid && r_bundle.we && (r_bundle.rd != 5'd0)
                      && !w_misalign && w_sel_ok;

  assign wb.W_A3          = r_bundle.rd;
  assign wb.W_WD3         = w_wd;
  assign wb.W_WE          = w_we;
  assign wb.W_pc          = r_bundle.pc;
  assign wb.W_fwd_valid   = w_we;
  assign wb.W_ld_misalign = w_misalign;
  assign wb.retire_cnt    = r_retire_cnt;

`ifdef WB_TRACE_EN
  always @(posedge clk) begin
    if (w_we) $display("%d@%h: $%d <= %h", $time, r_bundle.pc, r_bundle.rd, w_wd);
  end
`else
  // Hardware-only build: no commit trace.
`endif
endmodule
`default_nettype wire

// File: tb/tb_w_writeback.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_w_writeback : randomized and directed checks against a reference model |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_w_writeback;
  typedef struct {
    bit          valid;
    bit          flush;
    logic [31:0] pc;
    logic [4:0]  rd;
    bit          we;
    logic [2:0]  sel;
    logic [2:0]  ld;
    logic [1:0]  off;
    logic [31:0] alu, dm, hi, lo;
  } stim_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
    logic        fwd;
    logic        mis;
  } out_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_cnt = '0;

  w_writeback_if #(.WB_SEL_W(3), .CNT_W(32)) bus ();
  w_writeback #(.WB_SEL_W(3), .CNT_W(32)) dut (.clk(clk), .reset_n(reset_n), .wb(bus));

  always #5 clk = ~clk;

  function automatic out_t observed();
    return {bus.W_WE, bus.W_A3, bus.W_WD3, bus.W_pc, bus.W_fwd_valid, bus.W_ld_misalign};
  endfunction

  // Reference: plain shifts and arithmetic from the stage's rules.
  function automatic out_t model(stim_t s);
    out_t        o;
    logic [31:0] v, b, h;
    bit          mis, ok;
    o = '0;
    if (!s.valid || s.flush) return o;
    mis = 0; ok = 1; v = 0;
    case (s.sel)
      3'd0: v = s.alu;
      3'd1: begin
        b = (s.dm >> (8 * s.off)) % 256;
        h = (s.dm >> (16 * (s.off / 2))) % 65536;
        case (s.ld)
          3'd0: begin v = s.dm; mis = (s.off != 0); end
          3'd1: v = (b >= 128) ? b + 32'hFFFF_FF00 : b;
          3'd2: v = b;
          3'd3: begin v = (h >= 32768) ? h + 32'hFFFF_0000 : h; mis = (s.off % 2 == 1); end
          3'd4: begin v = h; mis = (s.off % 2 == 1); end
          default: v = s.dm;
        endcase
      end
      3'd2: v = s.pc + 32'd8;
      3'd3: v = s.hi;
      3'd4: v = s.lo;
      default: begin v = 0; ok = 0; end
    endcase
    o.pc  = s.pc;
    o.a3  = s.rd;
    o.wd  = v;
    o.mis = mis;
    o.we  = s.we && (s.rd != 0) && !mis && ok;
    o.fwd = o.we;
    return o;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{valid: 0, flush: 0, pc: 0, rd: 0, we: 0, sel: 0, ld: 0, off: 0,
          alu: 0, dm: 0, hi: 0, lo: 0};
    return s;
  endfunction

  task automatic put(stim_t s);
    bus.M_valid   = s.valid;
    bus.M_flush   = s.flush;
    bus.M_pc      = s.pc;
    bus.M_rd      = s.rd;
    bus.M_we      = s.we;
    bus.M_wb_sel  = s.sel;
    bus.M_ld_type = s.ld;
    bus.M_addr_lo = s.off;
    bus.M_alu     = s.alu;
    bus.M_dm      = s.dm;
    bus.M_hi      = s.hi;
    bus.M_lo      = s.lo;
  endtask

  // Present a bundle before an edge, then settle just after it.
  task automatic drive(stim_t s);
    @(negedge clk);
    put(s);
    @(posedge clk);
    #1;
    if (reset_n && s.valid && !s.flush) exp_cnt = exp_cnt + 1;
  endtask

  task automatic test_reset();
    put(idle());
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (observed() !== out_t'('0)) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", observed());
    end
    checks++;
    if (bus.retire_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", bus.retire_cnt);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_alu();
    stim_t s;
    s = idle(); s.valid = 1; s.rd = 5; s.we = 1; s.sel = 0; s.alu = 32'h1234_5678; s.pc = 32'h0000_3000;
    drive(s);
    checks++;
    if ({bus.W_WE, bus.W_A3, bus.W_WD3} !== {1'b1, 5'd5, 32'h1234_5678}) begin
      errors++; $display("FAIL alu_write: got we=%b a3=%0d wd=%h want we=1 a3=5 wd=12345678",
                         bus.W_WE, bus.W_A3, bus.W_WD3);
    end
    checks++;
    if (bus.retire_cnt !== 32'd1) begin
      errors++; $display("FAIL alu_retire: got %0d want 1", bus.retire_cnt);
    end
  endtask

  task automatic test_loads();
    stim_t s;
    logic [2:0]  lds  [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [1:0]  offs [4] = '{2'd3, 2'd3, 2'd2, 2'd0};
    logic [31:0] want [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.valid = 1; s.rd = 5'(8 + i); s.we = 1; s.sel = 1;
      s.ld = lds[i]; s.off = offs[i]; s.dm = 32'h80FF_7F01;
      drive(s);
      checks++;
      if (bus.W_WD3 !== want[i] || bus.W_WE !== 1'b1) begin
        errors++; $display("FAIL load_%0d: got wd=%h we=%b want wd=%h we=1",
                           i, bus.W_WD3, bus.W_WE, want[i]);
      end
    end
  endtask

  task automatic test_misalign();
    stim_t s;
    s = idle(); s.valid = 1; s.rd = 7; s.we = 1; s.sel = 1; s.ld = 0; s.off = 2; s.dm = 32'hCAFE_F00D;
    drive(s);
    checks++;
    if ({bus.W_ld_misalign, bus.W_WE} !== 2'b10) begin
      errors++; $display("FAIL lw_misalign: got mis=%b we=%b want mis=1 we=0", bus.W_ld_misalign, bus.W_WE);
    end
    s.ld = 3; s.off = 1;
    drive(s);
    checks++;
    if ({bus.W_ld_misalign, bus.W_WE} !== 2'b10) begin
      errors++; $display("FAIL lh_misalign: got mis=%b we=%b want mis=1 we=0", bus.W_ld_misalign, bus.W_WE);
    end
    s.sel = 0; s.ld = 0; s.off = 2;
    drive(s);
    checks++;
    if ({bus.W_ld_misalign, bus.W_WE} !== 2'b01) begin
      errors++; $display("FAIL alu_offset_not_load: got mis=%b we=%b want mis=0 we=1", bus.W_ld_misalign, bus.W_WE);
    end
  endtask

  task automatic test_zero_rd();
    stim_t s;
    s = idle(); s.valid = 1; s.rd = 0; s.we = 1; s.sel = 0; s.alu = 32'hDEAD_BEEF;
    drive(s);
    checks++;
    if ({bus.W_WE, bus.W_fwd_valid} !== 2'b00) begin
      errors++; $display("FAIL rd0_suppress: got we=%b fwd=%b want 0 0", bus.W_WE, bus.W_fwd_valid);
    end
    checks++;
    if (bus.retire_cnt !== exp_cnt) begin
      errors++; $display("FAIL rd0_retire: got %0d want %0d", bus.retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_flush_pc8();
    stim_t s;
    s = idle(); s.valid = 1; s.flush = 1; s.rd = 9; s.we = 1; s.sel = 0; s.alu = 32'h5555_AAAA; s.pc = 32'h40;
    drive(s);
    checks++;
    if (observed() !== out_t'('0) || bus.retire_cnt !== exp_cnt) begin
      errors++; $display("FAIL flush_bubble: got out=%h cnt=%0d want out=0 cnt=%0d",
                         observed(), bus.retire_cnt, exp_cnt);
    end
    s.flush = 0; s.sel = 2; s.pc = 32'hFFFF_FFFC; s.rd = 31;
    drive(s);
    checks++;
    if ({bus.W_WE, bus.W_WD3} !== {1'b1, 32'h0000_0004}) begin
      errors++; $display("FAIL pc8_wrap: got we=%b wd=%h want we=1 wd=00000004", bus.W_WE, bus.W_WD3);
    end
  endtask

  task automatic test_random();
    stim_t s;
    out_t  e;
    for (int n = 0; n < 300; n++) begin
      s.valid = ($urandom_range(0, 7) != 0);
      s.flush = ($urandom_range(0, 9) == 0);
      s.pc    = $urandom & 32'hFFFF_FFFC;
      s.rd    = 5'($urandom_range(0, 31));
      s.we    = ($urandom_range(0, 4) != 0);
      s.sel   = 3'($urandom_range(0, 7));
      s.ld    = 3'($urandom_range(0, 4));
      s.off   = 2'($urandom_range(0, 3));
      s.alu   = $urandom; s.dm = $urandom; s.hi = $urandom; s.lo = $urandom;
      drive(s);
      e = model(s);
      checks++;
      if (observed() !== e || bus.retire_cnt !== exp_cnt) begin
        errors++; $display("FAIL random_%0d: got out=%h cnt=%0d want out=%h cnt=%0d",
                           n, observed(), bus.retire_cnt, e, exp_cnt);
      end
    end
  endtask

  task automatic test_async_reset();
    stim_t s;
    s = idle(); s.valid = 1; s.rd = 12; s.we = 1; s.sel = 3; s.hi = 32'h0BAD_F00D; s.pc = 32'h100;
    drive(s);
    checks++;
    if (bus.W_WE !== 1'b1) begin
      errors++; $display("FAIL pre_reset_we: got %b want 1", bus.W_WE);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (observed() !== out_t'('0) || bus.retire_cnt !== 32'd0) begin
      errors++; $display("FAIL async_reset: got out=%h cnt=%0d want 0 0", observed(), bus.retire_cnt);
    end
    exp_cnt = 0;
    @(posedge clk);
    #1;
    checks++;
    if (observed() !== out_t'('0)) begin
      errors++; $display("FAIL held_in_reset: got %h want 0", observed());
    end
    #2;
    reset_n = 1'b1;
    #1;
    checks++;
    if (observed() !== out_t'('0)) begin
      errors++; $display("FAIL release_no_capture: got %h want 0", observed());
    end
    s.rd = 13; s.sel = 4; s.lo = 32'h1357_9BDF;
    drive(s);
    e_check(s);
  endtask

  task automatic e_check(stim_t s);
    out_t e;
    e = model(s);
    checks++;
    if (observed() !== e || bus.retire_cnt !== 32'd1) begin
      errors++; $display("FAIL first_capture: got out=%h cnt=%0d want out=%h cnt=1",
                         observed(), bus.retire_cnt, e);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_misalign();
    test_zero_rd();
    test_flush_pc8();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
